// File: rtl/dadda_reduce_16.sv
// dadda_reduce_16: pipelined 16x16 unsigned Dadda reduction to two rows.
// Build option DADDA_PIPE3_EN adds a register at tree height 6 (LAT 3).
//
// Ports:
//   aclk, aresetn     clock, synchronous active-low reset
//   s_valid/s_ready   operand handshake; s_a, s_b operands, s_tag sideband
//   m_valid/m_ready   row handshake; m_row0 (sum), m_row1 (carry), m_tag
//   occupancy         operations currently held (0..LAT)
// Without DADDA_PIPE3_EN: S1 operands -> full tree -> S2 rows, LAT 2.
// The downstream adder forms the product as m_row0 + m_row1, carry-in 0.

module dadda_reduce_16 #(
  parameter int TAG_W = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [15:0]      s_a,
  input  logic [15:0]      s_b,
  input  logic [TAG_W-1:0] s_tag,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_row0,
  output logic [31:0]      m_row1,
  output logic [TAG_W-1:0] m_tag,
  output logic [1:0]       occupancy
);

  // Column-major bit matrix: [column weight][slot within column].
  typedef logic [31:0][15:0] cols_t;
  typedef logic [31:0][5:0]  c6_t;
  typedef logic [31:0][4:0]  hts_t;

  // Partial-product column heights of a 16x16 array.
  function automatic hts_t pp_h();
    hts_t o;
    o = '0;
    for (int c = 0; c < 31; c++) begin
      o[c] = (c < 16) ? 5'(c + 1) : 5'(31 - c);
    end
    return o;
  endfunction

  function automatic cols_t pp_cols(
    input logic [15:0] x,
    input logic [15:0] y
  );
    cols_t o;
    int    k;
    o = '0;
    for (int c = 0; c < 31; c++) begin
      k = 0;
      for (int i = 0; i < 16; i++) begin
        if (c - i >= 0 && c - i < 16) begin
          o[c][k] = x[i] & y[c - i];
          k++;
        end
      end
    end
    return o;
  endfunction

  // Heights after one Dadda level with target d. Columns are walked
  // from LSB; carries from column c-1 count toward column c. A half
  // adder is used only when exactly one bit over target, else a full.
  function automatic hts_t lvl_h(input hts_t h, input int d);
    hts_t o;
    int   n;
    int   cin;
    int   nc;
    o   = '0;
    cin = 0;
    for (int c = 0; c < 32; c++) begin
      n  = int'(h[c]) + cin;
      nc = 0;
      for (int k = 0; k < 8; k++) begin
        if (n > d) begin
          n = (n == d + 1) ? n - 1 : n - 2;
          nc++;
        end
      end
      o[c] = 5'(n);
      cin  = nc;
    end
    return o;
  endfunction

  // Bit-level twin of lvl_h: same placement decisions, real adders.
  // Carries out of column 31 drop (result is mod 2^32).
  function automatic cols_t lvl_b(
    input cols_t bm,
    input hts_t  h,
    input int    d
  );
    cols_t       o;
    logic [31:0] w;
    logic [15:0] cv;
    logic [15:0] ncv;
    int          n;
    int          tot;
    int          p;
    int          q;
    int          cn;
    int          nc;
    o  = '0;
    cv = '0;
    cn = 0;
    for (int c = 0; c < 32; c++) begin
      w = '0;
      for (int i = 0; i < 16; i++) begin
        if (i < int'(h[c])) w[i] = bm[c][i];
      end
      for (int i = 0; i < 16; i++) begin
        if (i < cn) w[int'(h[c]) + i] = cv[i];
      end
      tot = int'(h[c]) + cn;
      n   = tot;
      p   = 0;
      q   = 0;
      nc  = 0;
      ncv = '0;
      for (int k = 0; k < 8; k++) begin
        if (n > d) begin
          if (n == d + 1) begin
            o[c][q] = w[p] ^ w[p+1];
            ncv[nc] = w[p] & w[p+1];
            p = p + 2;
            n = n - 1;
          end else begin
            o[c][q] = w[p] ^ w[p+1] ^ w[p+2];
            ncv[nc] = (w[p] & w[p+1])
                    | (w[p+2] & (w[p] ^ w[p+1]));
            p = p + 3;
            n = n - 2;
          end
          q++;
          nc++;
        end
      end
      for (int i = 0; i < 32; i++) begin
        if (i >= p && i < tot) begin
          o[c][q] = w[i];
          q++;
        end
      end
      cv = ncv;
      cn = nc;
    end
    return o;
  endfunction

  // Heights once the tree reaches six rows (after 13, 9, 6).
  function automatic hts_t h6();
    hts_t h;
    h = pp_h();
    h = lvl_h(h, 13);
    h = lvl_h(h, 9);
    h = lvl_h(h, 6);
    return h;
  endfunction

  // First three levels: 16 -> 13 -> 9 -> 6.
  function automatic c6_t head6(
    input logic [15:0] x,
    input logic [15:0] y
  );
    cols_t m;
    hts_t  h;
    c6_t   o;
    m = pp_cols(x, y);
    h = pp_h();
    m = lvl_b(m, h, 13);
    h = lvl_h(h, 13);
    m = lvl_b(m, h, 9);
    h = lvl_h(h, 9);
    m = lvl_b(m, h, 6);
    o = '0;
    for (int c = 0; c < 32; c++) begin
      for (int i = 0; i < 16; i++) begin
        if (i < 6) o[c][i] = m[c][i];
      end
    end
    return o;
  endfunction

  // Last three levels: 6 -> 4 -> 3 -> 2; returns {row1, row0}.
  function automatic logic [63:0] tail(input c6_t s);
    cols_t       m;
    hts_t        h;
    logic [63:0] r;
    m = '0;
    for (int c = 0; c < 32; c++) begin
      for (int i = 0; i < 6; i++) m[c][i] = s[c][i];
    end
    h = h6();
    m = lvl_b(m, h, 4);
    h = lvl_h(h, 4);
    m = lvl_b(m, h, 3);
    h = lvl_h(h, 3);
    m = lvl_b(m, h, 2);
    r = '0;
    for (int c = 0; c < 32; c++) begin
      for (int i = 0; i < 16; i++) begin
        if (i == 0) r[c]      = m[c][i];
        if (i == 1) r[32 + c] = m[c][i];
      end
    end
    return r;
  endfunction

  logic             s1_valid;
  logic [15:0]      s1_a;
  logic [15:0]      s1_b;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid;
  logic [31:0]      s2_row0;
  logic [31:0]      s2_row1;
  logic [TAG_W-1:0] s2_tag;
  logic [1:0]       occ;

  logic             out_adv;
  logic             s1_go;
  logic             accept;
  logic             emit;
  logic             t_valid;
  c6_t              t_cols;
  logic [TAG_W-1:0] t_tag;
  logic [63:0]      rows_d;

  assign out_adv = !s2_valid || m_ready;

`ifdef DADDA_PIPE3_EN
  logic             s1b_valid;
  c6_t              s1b_cols;
  logic [TAG_W-1:0] s1b_tag;
  logic             mid_adv;

  assign mid_adv = !s1b_valid || out_adv;
  assign s1_go   = mid_adv;
  assign t_valid = s1b_valid;
  assign t_cols  = s1b_cols;
  assign t_tag   = s1b_tag;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s1b_valid <= 1'b0;
      s1b_cols  <= '0;
      s1b_tag   <= '0;
    end else if (mid_adv) begin
      s1b_valid <= s1_valid;
      if (s1_valid) begin
        s1b_cols <= head6(s1_a, s1_b);
        s1b_tag  <= s1_tag;
      end
    end
  end
`else
  assign s1_go   = out_adv;
  assign t_valid = s1_valid;
  assign t_cols  = head6(s1_a, s1_b);
  assign t_tag   = s1_tag;
`endif

  assign rows_d = tail(t_cols);

  // No s_valid term here: ready depends only on state and m_ready.
  assign s_ready = aresetn && (!s1_valid || s1_go);
  assign m_valid = aresetn && s2_valid;
  assign accept  = s_valid && s_ready;
  assign emit    = m_valid && m_ready;

  assign m_row0    = s2_row0;
  assign m_row1    = s2_row1;
  assign m_tag     = s2_tag;
  assign occupancy = occ;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
    end else if (!s1_valid || s1_go) begin
      s1_valid <= s_valid;
      if (s_valid) begin
        s1_a   <= s_a;
        s1_b   <= s_b;
        s1_tag <= s_tag;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s2_valid <= 1'b0;
      s2_row0  <= '0;
      s2_row1  <= '0;
      s2_tag   <= '0;
    end else if (out_adv) begin
      s2_valid <= t_valid;
      if (t_valid) begin
        s2_row0 <= rows_d[31:0];
        s2_row1 <= rows_d[63:32];
        s2_tag  <= t_tag;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      occ <= '0;
    end else begin
      unique case (1'b1)
        accept && !emit: occ <= occ + 2'd1;
        emit && !accept: occ <= occ - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dadda_reduce_16.sv
// tb_dadda_reduce_16: scoreboard bench for dadda_reduce_16.
// Expected products come from plain multiplication of accepted operands.

module tb_dadda_reduce_16;

  localparam int TAG_W = 4;
`ifdef DADDA_PIPE3_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic             aclk;
  logic             aresetn;
  logic             s_valid;
  logic             s_ready;
  logic [15:0]      s_a;
  logic [15:0]      s_b;
  logic [TAG_W-1:0] s_tag;
  logic             m_valid;
  logic             m_ready;
  logic [31:0]      m_row0;
  logic [31:0]      m_row1;
  logic [TAG_W-1:0] m_tag;
  logic [1:0]       occupancy;

  dadda_reduce_16 #(.TAG_W(TAG_W)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_a       (s_a),
    .s_b       (s_b),
    .s_tag     (s_tag),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_row0    (m_row0),
    .m_row1    (m_row1),
    .m_tag     (m_tag),
    .occupancy (occupancy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [31:0]      p;
    logic [TAG_W-1:0] t;
  } exp_t;

  exp_t             sb[$];
  bit               mv_hist[$];
  int               checks = 0;
  int               errors = 0;
  int               emits = 0;
  bit               mon_en = 1'b0;
  bit               acc = 1'b0;
  logic [31:0]      last_sum = '0;

  function automatic void chk(
    input bit          ok,
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] want
  );
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endfunction

  // Monitor: samples at the falling edge, pops on every transfer out.
  initial begin
    bit               hold;
    logic [31:0]      h0;
    logic [31:0]      h1;
    logic [TAG_W-1:0] ht;
    logic [31:0]      sum;
    exp_t             e;
    hold = 1'b0;
    h0 = '0;
    h1 = '0;
    ht = '0;
    forever begin
      @(negedge aclk);
      if (mon_en) begin
        chk(int'(occupancy) == sb.size(), "occupancy",
            64'(occupancy), 64'(sb.size()));
        if (hold && aresetn) begin
          chk(m_valid && m_row0 == h0 && m_row1 == h1 && m_tag == ht,
              "hold_stable", {m_row1, m_row0}, {h1, h0});
        end
        hold = 1'b0;
        if (m_valid) begin
          if (m_ready) begin
            sum = m_row0 + m_row1;
            chk(sb.size() != 0, "unexpected_output", 64'(sum), 64'(0));
            if (sb.size() != 0) begin
              e = sb.pop_front();
              chk(sum == e.p, "product", 64'(sum), 64'(e.p));
              chk(m_tag == e.t, "tag", 64'(m_tag), 64'(e.t));
              last_sum = sum;
              emits++;
            end
          end else begin
            hold = 1'b1;
            h0   = m_row0;
            h1   = m_row1;
            ht   = m_tag;
          end
        end
      end
    end
  end

  task automatic step();
    exp_t e;
    @(negedge aclk);
    acc = s_valid && s_ready;
    mv_hist.push_back(m_valid);
    @(posedge aclk);
    if (acc) begin
      e.p = {16'h0, s_a} * {16'h0, s_b};
      e.t = s_tag;
      sb.push_back(e);
    end
    #1;
  endtask

  task automatic send(
    input  logic [15:0]      a,
    input  logic [15:0]      b,
    input  logic [TAG_W-1:0] t,
    output int               n
  );
    s_valid = 1'b1;
    s_a     = a;
    s_b     = b;
    s_tag   = t;
    n       = 0;
    do begin
      step();
      n++;
    end while (!acc && n < 200);
    chk(acc, "send_accept", 64'(n), 64'(1));
  endtask

  task automatic drain();
    int n;
    s_valid = 1'b0;
    m_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      step();
      n++;
    end
    chk(sb.size() == 0, "drain", 64'(sb.size()), 64'(0));
  endtask

  task automatic corner(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [31:0] want
  );
    int n;
    send(a, b, TAG_W'(5), n);
    drain();
    chk(last_sum == want, "corner", 64'(last_sum), 64'(want));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int j;
    int k;
    int bad;
    int acc_n;
    int cyc;

    aresetn = 1'b0;
    s_valid = 1'b0;
    s_a     = '0;
    s_b     = '0;
    s_tag   = '0;
    m_ready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk(!s_ready, "reset_s_ready", 64'(s_ready), 64'(0));
    chk(!m_valid, "reset_m_valid", 64'(m_valid), 64'(0));
    chk(occupancy == 2'd0, "reset_occ", 64'(occupancy), 64'(0));
    aresetn = 1'b1;
    #1;
    chk(s_ready, "ready_after_reset", 64'(s_ready), 64'(1));
    mon_en = 1'b1;

    // Single op, latency and occupancy return.
    m_ready = 1'b1;
    mv_hist.delete();
    send(16'hFFFF, 16'hFFFF, TAG_W'(3), n);
    drain();
    chk(last_sum == 32'hFFFE0001, "max_product",
        64'(last_sum), 64'h0FFFE0001);
    k = -1;
    for (int i = mv_hist.size() - 1; i >= 0; i--) begin
      if (mv_hist[i]) k = i;
    end
    chk(k == LAT, "latency", 64'(k), 64'(LAT));
    chk(occupancy == 2'd0, "occ_idle", 64'(occupancy), 64'(0));

    corner(16'h0000, 16'h1234, 32'h00000000);
    corner(16'h0001, 16'hABCD, 32'h0000ABCD);
    corner(16'h8000, 16'h8000, 32'h40000000);

    // Back-to-back stream: no stalls, no bubbles at the output.
    mv_hist.delete();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(16'(i * 'h1111), 16'('hFFFF - i), TAG_W'(i), n);
      chk(n == 1, "stream_no_stall", 64'(n), 64'(1));
    end
    s_valid = 1'b0;
    repeat (LAT + 2) step();
    bad = 0;
    for (int i = 0; i < mv_hist.size(); i++) begin
      if (mv_hist[i] != (i >= LAT && i < LAT + 8)) bad++;
    end
    chk(bad == 0, "stream_pattern", 64'(bad), 64'(0));
    drain();

    // Backpressure: fill, stall, then release.
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_a     = 16'($urandom);
    s_b     = 16'($urandom);
    s_tag   = TAG_W'($urandom);
    j = 0;
    repeat (LAT + 3) begin
      step();
      if (acc) begin
        j++;
        s_a   = 16'($urandom);
        s_b   = 16'($urandom);
        s_tag = TAG_W'($urandom);
      end
    end
    chk(j == LAT, "bp_accepted", 64'(j), 64'(LAT));
    chk(int'(occupancy) == LAT, "bp_occ", 64'(occupancy), 64'(LAT));
    chk(!s_ready, "bp_s_ready", 64'(s_ready), 64'(0));
    repeat (5) begin
      step();
      chk(!acc, "bp_no_accept", 64'(acc), 64'(0));
    end
    m_ready = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!acc && n < 50);
    chk(acc, "bp_resume", 64'(acc), 64'(1));
    drain();

    // Reset with two operations in flight.
    m_ready = 1'b0;
    send(16'h0102, 16'h0304, TAG_W'(1), n);
    send(16'h0506, 16'h0708, TAG_W'(2), n);
    s_valid = 1'b0;
    aresetn = 1'b0;
    #1;
    chk(!s_ready, "mid_rst_s_ready", 64'(s_ready), 64'(0));
    chk(!m_valid, "mid_rst_m_valid", 64'(m_valid), 64'(0));
    step();
    sb.delete();
    chk(occupancy == 2'd0, "mid_rst_occ", 64'(occupancy), 64'(0));
    chk(!m_valid, "mid_rst_m_valid2", 64'(m_valid), 64'(0));
    aresetn = 1'b1;
    m_ready = 1'b1;
    j = emits;
    send(16'h0003, 16'h0005, TAG_W'(7), n);
    s_valid = 1'b0;
    drain();
    repeat (LAT + 2) step();
    chk(last_sum == 32'h0000000F, "post_rst_sum",
        64'(last_sum), 64'hF);
    chk(emits - j == 1, "post_rst_emits", 64'(emits - j), 64'(1));

    // Random traffic with random valid/ready.
    acc     = 1'b0;
    s_valid = 1'b0;
    acc_n   = 0;
    cyc     = 0;
    while (acc_n < 10000 && cyc < 60000) begin
      if (!s_valid || acc) begin
        s_a     = 16'($urandom);
        s_b     = 16'($urandom);
        s_tag   = TAG_W'($urandom);
        s_valid = ($urandom_range(0, 3) != 0);
      end
      m_ready = ($urandom_range(0, 3) != 0);
      step();
      if (acc) acc_n++;
      cyc++;
    end
    chk(acc_n == 10000, "random_count", 64'(acc_n), 64'(10000));
    drain();
    chk(occupancy == 2'd0, "final_occ", 64'(occupancy), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
